psum_drain: RTL and testbench

PSUM_DRAIN -- requirements
Module: psum_drain

---
 rtl/psum_drain.sv | 101 ++++++++++
 tb/tb_psum_drain.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// Drains POX parallel MAC results into a serial word stream through a
// two-entry group buffer, stalling the MAC bank while both entries are full.
module psum_drain #(
    parameter int DW  = 32,
    parameter int POX = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DW-1:0]           res_in  [POX],
    input  logic                    done_in [POX],
    output logic                    hold,
    output logic [DW-1:0]           out_data,
    output logic [$clog2(POX)-1:0]  out_idx,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err
);

    localparam int IW = $clog2(POX);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q, state_d;
    logic [1:0]      count_q, count_d;
    logic            wr_q, wr_d;
    logic            rd_q, rd_d;
    logic [IW-1:0]   lane_q, lane_d;
    logic            err_q, err_d;
    logic [DW-1:0]   mem_q [2][POX];

    logic allDone, anyDone, protoErr;
    logic handshake, lastLane, pop, accept;

    always_comb begin
        allDone = 1'b1;
        anyDone = 1'b0;
        for (int i = 0; i < POX; i++) begin
            allDone = allDone & done_in[i];
            anyDone = anyDone | done_in[i];
        end
        protoErr  = anyDone & ~allDone;
        handshake = (state_q == SEND) & out_ready;
        lastLane  = (lane_q == IW'(POX - 1));
        pop       = handshake & lastLane;
        // A full buffer can still take a group when its head leaves in the same cycle.
        accept    = allDone & ((count_q != 2'd2) | pop);
    end

    always_comb begin
        count_d = count_q + {1'b0, accept} - {1'b0, pop};
        wr_d    = wr_q ^ accept;
        rd_d    = rd_q ^ pop;
        lane_d  = lane_q;
        err_d   = err_q | protoErr | (allDone & ~accept);
        state_d = state_q;
        if (handshake) begin
            lane_d = lastLane ? '0 : lane_q + IW'(1);
        end
        case (state_q)
            IDLE:    if (count_d != 2'd0) state_d = SEND;
            SEND:    if (pop && count_d == 2'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 2'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            lane_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            lane_q  <= lane_d;
            err_q   <= err_d;
        end
    end

    // Buffer contents are only meaningful once counted, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < POX; i++) begin
                mem_q[wr_q][i] <= res_in[i];
            end
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? mem_q[rd_q][lane_q] : '0;
    assign out_idx   = lane_q;
    assign out_last  = out_valid & lastLane;
    assign hold      = (count_q == 2'd2);
    assign err       = err_q;

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain (POX=3): directed scenarios plus a
// randomized run against a queue-of-groups reference model.
module tb_psum_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] res_in  [3];
    logic        done_in [3];
    logic        hold;
    logic [31:0] out_data;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    int asserts  = 0;
    int failures = 0;

    typedef logic [31:0] grp_t [3];
    grp_t gq[$];
    int   mlane;
    bit   merr;

    logic [31:0] logData[$];
    logic [1:0]  logIdx[$];
    logic        logLast[$];
    logic        sValid;
    logic [31:0] sData;
    logic [1:0]  sIdx;

    psum_drain #(.DW(32), .POX(3)) dut (
        .clk(clk), .rst(rst), .res_in(res_in), .done_in(done_in),
        .hold(hold), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic setInputs(input bit [2:0] d, input logic [31:0] a, b, c, input bit r);
        done_in[0] = d[0];
        done_in[1] = d[1];
        done_in[2] = d[2];
        res_in[0]  = a;
        res_in[1]  = b;
        res_in[2]  = c;
        out_ready  = r;
    endtask

    task automatic clearLogs();
        logData.delete();
        logIdx.delete();
        logLast.delete();
    endtask

    // Drives one cycle from posedge+1, observes mid-cycle, returns at posedge+1.
    task automatic drive_cycle(input bit [2:0] d, input logic [31:0] a, b, c, input bit r);
        setInputs(d, a, b, c, r);
        @(negedge clk);
        sValid = out_valid;
        sData  = out_data;
        sIdx   = out_idx;
        if (out_valid && out_ready) begin
            logData.push_back(out_data);
            logIdx.push_back(out_idx);
            logLast.push_back(out_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        setInputs(3'b000, 0, 0, 0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        gq.delete();
        mlane = 0;
        merr  = 1'b0;
        clearLogs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        setInputs(3'b000, 0, 0, 0, 1'b0);
        #2;
        asserts++;
        if (out_valid !== 1'b0 || hold !== 1'b0 || err !== 1'b0 || out_idx !== 2'd0 ||
            out_last !== 1'b0 || out_data !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: valid=%b hold=%b err=%b idx=%0d last=%b data=%0d, required all zero",
                     out_valid, hold, err, out_idx, out_last, out_data);
        end
        do_reset();
    endtask

    task automatic test_single_group();
        logic [31:0] exp [3];
        exp[0] = 10; exp[1] = 20; exp[2] = 30;
        do_reset();
        drive_cycle(3'b111, 10, 20, 30, 1'b1);
        asserts++;
        if (out_valid !== 1'b1 || out_data !== 32'd10 || out_idx !== 2'd0) begin
            failures++;
            $display("[TB] FAIL single_latency: valid=%b data=%0d idx=%0d, required 1/10/0",
                     out_valid, out_data, out_idx);
        end
        for (int i = 0; i < 3; i++) drive_cycle(3'b000, 0, 0, 0, 1'b1);
        asserts++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_idle: out_valid=%b, required 0", out_valid);
        end
        asserts++;
        if (logData.size() != 3) begin
            failures++;
            $display("[TB] FAIL single_count: words=%0d, required 3", logData.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                asserts++;
                if (logData[i] !== exp[i] || logIdx[i] !== 2'(i) || logLast[i] !== (i == 2)) begin
                    failures++;
                    $display("[TB] FAIL single_word%0d: data=%0d idx=%0d last=%b, required %0d/%0d/%b",
                             i, logData[i], logIdx[i], logLast[i], exp[i], i, (i == 2));
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] g [3];
        for (int i = 0; i < 3; i++) g[i] = $urandom;
        do_reset();
        drive_cycle(3'b111, g[0], g[1], g[2], 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(3'b000, 0, 0, 0, bit'(i % 2));
            asserts++;
            if (sValid !== 1'b1 || sData !== g[i / 2] || sIdx !== 2'(i / 2)) begin
                failures++;
                $display("[TB] FAIL bp_stable%0d: valid=%b data=%h idx=%0d, required 1/%h/%0d",
                         i, sValid, sData, sIdx, g[i / 2], i / 2);
            end
        end
        asserts++;
        if (out_valid !== 1'b0 || logData.size() != 3) begin
            failures++;
            $display("[TB] FAIL bp_drain: valid=%b words=%0d, required 0/3", out_valid, logData.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                asserts++;
                if (logData[i] !== g[i]) begin
                    failures++;
                    $display("[TB] FAIL bp_word%0d: data=%h, required %h", i, logData[i], g[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp [6];
        for (int i = 0; i < 6; i++) exp[i] = 32'h100 + i;
        do_reset();
        drive_cycle(3'b111, exp[0], exp[1], exp[2], 1'b0);
        drive_cycle(3'b111, exp[3], exp[4], exp[5], 1'b0);
        asserts++;
        if (hold !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_full: hold=%b err=%b, required 1/0", hold, err);
        end
        drive_cycle(3'b111, 32'hDEAD, 32'hBEEF, 32'hCAFE, 1'b0);
        asserts++;
        if (err !== 1'b1 || hold !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_err: err=%b hold=%b, required 1/1", err, hold);
        end
        for (int i = 0; i < 7; i++) drive_cycle(3'b000, 0, 0, 0, 1'b1);
        asserts++;
        if (out_valid !== 1'b0 || hold !== 1'b0 || err !== 1'b1 || logData.size() != 6) begin
            failures++;
            $display("[TB] FAIL ovf_drain: valid=%b hold=%b err=%b words=%0d, required 0/0/1/6",
                     out_valid, hold, err, logData.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                asserts++;
                if (logData[i] !== exp[i] || logIdx[i] !== 2'(i % 3)) begin
                    failures++;
                    $display("[TB] FAIL ovf_word%0d: data=%h idx=%0d, required %h/%0d",
                             i, logData[i], logIdx[i], exp[i], i % 3);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp [9];
        for (int i = 0; i < 9; i++) exp[i] = $urandom;
        do_reset();
        drive_cycle(3'b111, exp[0], exp[1], exp[2], 1'b0);
        drive_cycle(3'b111, exp[3], exp[4], exp[5], 1'b0);
        drive_cycle(3'b000, 0, 0, 0, 1'b1);
        drive_cycle(3'b000, 0, 0, 0, 1'b1);
        drive_cycle(3'b111, exp[6], exp[7], exp[8], 1'b1);
        asserts++;
        if (hold !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL simul_accept: hold=%b err=%b, required 1/0", hold, err);
        end
        for (int i = 0; i < 7; i++) drive_cycle(3'b000, 0, 0, 0, 1'b1);
        asserts++;
        if (out_valid !== 1'b0 || err !== 1'b0 || logData.size() != 9) begin
            failures++;
            $display("[TB] FAIL simul_drain: valid=%b err=%b words=%0d, required 0/0/9",
                     out_valid, err, logData.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                asserts++;
                if (logData[i] !== exp[i] || logLast[i] !== (i % 3 == 2)) begin
                    failures++;
                    $display("[TB] FAIL simul_word%0d: data=%h last=%b, required %h/%b",
                             i, logData[i], logLast[i], exp[i], (i % 3 == 2));
                end
            end
        end
    endtask

    task automatic test_protocol_error();
        do_reset();
        drive_cycle(3'b101, 1, 2, 3, 1'b1);
        asserts++;
        if (err !== 1'b1 || out_valid !== 1'b0 || hold !== 1'b0) begin
            failures++;
            $display("[TB] FAIL proto_err: err=%b valid=%b hold=%b, required 1/0/0", err, out_valid, hold);
        end
        drive_cycle(3'b000, 0, 0, 0, 1'b1);
        asserts++;
        if (out_valid !== 1'b0 || logData.size() != 0 || err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL proto_nocap: valid=%b words=%0d err=%b, required 0/0/1",
                     out_valid, logData.size(), err);
        end
    endtask

    task automatic test_reset_mid_send();
        logic [31:0] h [3];
        for (int i = 0; i < 3; i++) h[i] = $urandom;
        do_reset();
        drive_cycle(3'b111, 32'h11, 32'h22, 32'h33, 1'b1);
        drive_cycle(3'b000, 0, 0, 0, 1'b1);
        drive_cycle(3'b000, 0, 0, 0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        asserts++;
        if (out_valid !== 1'b0 || err !== 1'b0 || out_idx !== 2'd0 || hold !== 1'b0 ||
            out_last !== 1'b0 || out_data !== 32'd0) begin
            failures++;
            $display("[TB] FAIL midrst_async: valid=%b err=%b idx=%0d hold=%b last=%b data=%h, required all zero",
                     out_valid, err, out_idx, hold, out_last, out_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearLogs();
        drive_cycle(3'b111, h[0], h[1], h[2], 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(3'b000, 0, 0, 0, 1'b1);
        asserts++;
        if (logData.size() != 3 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_count: words=%0d valid=%b, required 3/0", logData.size(), out_valid);
        end else begin
            for (int i = 0; i < 3; i++) begin
                asserts++;
                if (logData[i] !== h[i] || logIdx[i] !== 2'(i)) begin
                    failures++;
                    $display("[TB] FAIL midrst_word%0d: data=%h idx=%0d, required %h/%0d",
                             i, logData[i], logIdx[i], h[i], i);
                end
            end
        end
    endtask

    task automatic test_random();
        bit [2:0]    d;
        bit          r;
        logic [31:0] a, b, c;
        int          n;
        bit          pop;
        grp_t        g;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            n = $urandom_range(0, 99);
            if (n < 30)      d = 3'b111;
            else if (n < 35) d = 3'($urandom_range(1, 6));
            else             d = 3'b000;
            r = ($urandom_range(0, 99) < 70);
            a = $urandom; b = $urandom; c = $urandom;
            setInputs(d, a, b, c, r);
            @(negedge clk);
            asserts++;
            if (out_valid !== (gq.size() > 0) || hold !== (gq.size() == 2) || err !== merr) begin
                failures++;
                $display("[TB] FAIL rand_ctrl cyc%0d: valid=%b hold=%b err=%b, required %b/%b/%b",
                         cyc, out_valid, hold, err, (gq.size() > 0), (gq.size() == 2), merr);
            end
            if (gq.size() > 0) begin
                asserts++;
                if (out_data !== gq[0][mlane] || out_idx !== 2'(mlane) || out_last !== (mlane == 2)) begin
                    failures++;
                    $display("[TB] FAIL rand_data cyc%0d: data=%h idx=%0d last=%b, required %h/%0d/%b",
                             cyc, out_data, out_idx, out_last, gq[0][mlane], mlane, (mlane == 2));
                end
            end
            @(posedge clk);
            n   = gq.size();
            pop = (n > 0) && r && (mlane == 2);
            if (n > 0 && r) begin
                if (mlane == 2) begin
                    mlane = 0;
                    void'(gq.pop_front());
                end else begin
                    mlane++;
                end
            end
            if (d == 3'b111) begin
                if (n < 2 || pop) begin
                    g[0] = a; g[1] = b; g[2] = c;
                    gq.push_back(g);
                end else begin
                    merr = 1'b1;
                end
            end else if (d != 3'b000) begin
                merr = 1'b1;
            end
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_back_pressure();
        test_overflow();
        test_simultaneous();
        test_protocol_error();
        test_reset_mid_send();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
